// File: rtl/sram_pkg.sv
// Shared helpers for the multi-port SRAM: byte-lane count and port-index width.
`default_nettype none

package sram_pkg;

  function automatic int lanes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
// Combinational round-robin arbiter; owns the rotating priority pointer.
`default_nettype none

module sram_rr_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                             clock,
  input  logic                             reset_b,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             grant,
  output logic [idx_width(NUM_PORTS)-1:0]  grant_idx
);

  localparam int IW = idx_width(NUM_PORTS);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;
  int            scan_idx;

  // Grants are forced low while reset is held so no transfer can slip through.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = 0;
    ptr_d     = ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
      if (!found && reset_b && req_valid[scan_idx]) begin
        found            = 1'b1;
        grant[scan_idx]  = 1'b1;
        grant_idx        = IW'(scan_idx);
      end
    end
    if (found) ptr_d = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + IW'(1);
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/sram_arb_mp.sv
// Multi-port SRAM: round-robin shared single-port array with byte enables,
// range checking and a fixed-latency read return pipeline.
`default_nettype none

module sram_arb_mp
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 256,
  parameter int NUM_PORTS    = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                                clock,
  input  logic                                reset_b,
  input  logic [NUM_PORTS-1:0]                req_valid,
  output logic [NUM_PORTS-1:0]                req_ready,
  input  logic [NUM_PORTS-1:0]                req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_write_data,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_byte_en,
  output logic [NUM_PORTS-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_read_data,
  output logic                                rsp_error,
  output logic                                wr_error
);

  localparam int LANES = lanes(DATA_WIDTH);
  localparam int IW    = idx_width(NUM_PORTS);
  localparam int LAST  = READ_LATENCY - 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [IW-1:0]         port;
    logic [DATA_WIDTH-1:0] data;
    logic                  error;
  } rd_entry_t;

  logic [NUM_PORTS-1:0]  grant;
  logic [IW-1:0]         gidx;
  logic                  xfer;
  logic                  sel_write;
  logic                  sel_oor;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [LANES-1:0]      sel_be;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_error_q;

  logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
  rd_entry_t             pipe_q [READ_LATENCY];
  rd_entry_t             pipe_d [READ_LATENCY];

  sram_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clock     (clock),
    .reset_b   (reset_b),
    .req_valid (req_valid),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready = grant;

  always_comb begin
    xfer      = |(req_valid & grant);
    sel_write = req_write[gidx];
    sel_addr  = req_address[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = req_write_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    sel_be    = req_byte_en[int'(gidx)*LANES +: LANES];
    sel_oor   = {1'b0, sel_addr} >= DEPTH_LIM;
    rd_data   = sel_oor ? '0 : mem_q[sel_addr];
  end

  always_ff @(posedge clock) begin
    if (xfer && sel_write && !sel_oor) begin
      for (int b = 0; b < LANES; b++) begin
        if (sel_be[b]) mem_q[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    pipe_d[0] = '{valid: xfer && !sel_write, port: gidx, data: rd_data, error: sel_oor};
    for (int k = 1; k < READ_LATENCY; k++) pipe_d[k] = pipe_q[k-1];
  end

  // Payload only advances with a valid entry, so the output data holds between responses.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      for (int k = 0; k < READ_LATENCY; k++) pipe_q[k] <= '0;
      wr_error_q <= 1'b0;
    end else begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_q[k].valid <= pipe_d[k].valid;
        if (pipe_d[k].valid) begin
          pipe_q[k].port  <= pipe_d[k].port;
          pipe_q[k].data  <= pipe_d[k].data;
          pipe_q[k].error <= pipe_d[k].error;
        end
      end
      wr_error_q <= xfer && sel_write && sel_oor;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (pipe_q[LAST].valid) rsp_valid[pipe_q[LAST].port] = 1'b1;
  end

  assign rsp_read_data = pipe_q[LAST].data;
  assign rsp_error     = pipe_q[LAST].valid && pipe_q[LAST].error;
  assign wr_error      = wr_error_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_arb_mp.sv
// Randomized bench for sram_arb_mp against a queue-based reference model.
`default_nettype none

module tb_sram_arb_mp;

  localparam int NP  = 4;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int DEP = 200;
  localparam int RL  = 2;
  localparam int BL  = DW / 8;

  logic              clock = 1'b0;
  logic              reset_b;
  logic [NP-1:0]     req_valid, req_ready, req_write, rsp_valid;
  logic [NP*AW-1:0]  req_address;
  logic [NP*DW-1:0]  req_write_data;
  logic [NP*BL-1:0]  req_byte_en;
  logic [DW-1:0]     rsp_read_data;
  logic              rsp_error, wr_error;

  logic              b_valid, b_ready, b_write, b_rsp_valid, b_rsp_error, b_wr_error;
  logic [7:0]        b_addr;
  logic [15:0]       b_wdata, b_rdata;
  logic [1:0]        b_be;

  always #5 clock = ~clock;

  sram_arb_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .NUM_PORTS(NP), .READ_LATENCY(RL)
  ) dut (
    .clock(clock), .reset_b(reset_b), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_address(req_address), .req_write_data(req_write_data),
    .req_byte_en(req_byte_en), .rsp_valid(rsp_valid), .rsp_read_data(rsp_read_data),
    .rsp_error(rsp_error), .wr_error(wr_error)
  );

  sram_arb_mp #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256), .NUM_PORTS(1), .READ_LATENCY(1)
  ) dut_b (
    .clock(clock), .reset_b(reset_b), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_address(b_addr), .req_write_data(b_wdata),
    .req_byte_en(b_be), .rsp_valid(b_rsp_valid), .rsp_read_data(b_rdata),
    .rsp_error(b_rsp_error), .wr_error(b_wr_error)
  );

  typedef struct {
    int          due;
    int          port;
    logic [15:0] data;
    bit          err;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          ptr     = 0;
  int          last_grant;
  bit          in_reset;
  bit          exp_wr_err;
  logic [15:0] last_data;
  logic [15:0] mmem [DEP];
  exp_t        rq [$];
  int          grant_cnt [NP];

  bit          p_valid [NP];
  bit          p_write [NP];
  logic [7:0]  p_addr  [NP];
  logic [15:0] p_data  [NP];
  logic [1:0]  p_be    [NP];

  logic [NP-1:0] obs_ready, obs_valid;
  logic [15:0]   obs_data;
  logic          obs_err, obs_wr_err;
  logic [15:0]   bexp [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) begin
      p_valid[p] = 0; p_write[p] = 0; p_addr[p] = '0; p_data[p] = '0; p_be[p] = '0;
    end
  endtask

  task automatic set_req(input int p, input bit w, input logic [7:0] a,
                         input logic [15:0] d, input logic [1:0] be);
    p_valid[p] = 1; p_write[p] = w; p_addr[p] = a; p_data[p] = d; p_be[p] = be;
  endtask

  task automatic rand_port(input int p);
    p_valid[p] = ($urandom_range(0, 9) < 6);
    p_write[p] = $urandom_range(0, 1);
    p_addr[p]  = 8'($urandom_range(0, 219));
    p_data[p]  = 16'($urandom);
    p_be[p]    = 2'($urandom_range(0, 3));
  endtask

  function automatic int pick();
    for (int i = 0; i < NP; i++) begin
      if (p_valid[(ptr + i) % NP]) return (ptr + i) % NP;
    end
    return -1;
  endfunction

  // One clock: drive, check at the falling edge, then advance the model.
  task automatic step();
    int   g;
    exp_t e;
    bit   oor;
    for (int p = 0; p < NP; p++) begin
      req_valid[p]                = p_valid[p];
      req_write[p]                = p_write[p];
      req_address[p*AW +: AW]     = p_addr[p];
      req_write_data[p*DW +: DW]  = p_data[p];
      req_byte_en[p*BL +: BL]     = p_be[p];
    end
    @(negedge clock);
    g          = in_reset ? -1 : pick();
    obs_ready  = req_ready;
    obs_valid  = rsp_valid;
    obs_data   = rsp_read_data;
    obs_err    = rsp_error;
    obs_wr_err = wr_error;
    check("ready", req_ready, (g < 0) ? 32'd0 : (32'd1 << g));
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      check("rsp_valid", rsp_valid, 32'd1 << e.port);
      check("rsp_data", rsp_read_data, e.data);
      check("rsp_err", rsp_error, e.err);
      last_data = e.data;
    end else begin
      check("rsp_idle", rsp_valid, 0);
      check("rsp_hold", rsp_read_data, last_data);
      check("rsp_err_idle", rsp_error, 0);
    end
    check("wr_err", wr_error, exp_wr_err);
    exp_wr_err = 0;
    for (int p = 0; p < NP; p++) if (req_ready[p]) grant_cnt[p]++;
    if (g >= 0) begin
      oor = (p_addr[g] >= DEP);
      if (p_write[g]) begin
        exp_wr_err = oor;
        if (!oor) begin
          for (int b = 0; b < BL; b++)
            if (p_be[g][b]) mmem[p_addr[g]][b*8 +: 8] = p_data[g][b*8 +: 8];
        end
      end else begin
        e.due = cyc + RL; e.port = g; e.err = oor;
        e.data = oor ? 16'h0 : mmem[p_addr[g]];
        rq.push_back(e);
      end
      ptr = (g + 1) % NP;
    end
    last_grant = g;
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic enter_reset();
    reset_b = 0; in_reset = 1; rq.delete(); ptr = 0; exp_wr_err = 0; last_data = '0;
  endtask

  initial begin
    clear_all();
    b_valid = 0; b_write = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    enter_reset();
    repeat (3) step();
    reset_b = 1; in_reset = 0;

    for (int a = 0; a < DEP; a++) begin
      clear_all(); set_req(0, 1, 8'(a), 16'($urandom), 2'b11); step();
    end
    clear_all();

    set_req(0, 1, 8'h10, 16'hBEEF, 2'b11); step(); clear_all();
    set_req(2, 0, 8'h10, 16'h0, 2'b00);    step(); clear_all();
    step(); step();
    check("tp_raw_valid", obs_valid, 4'b0100);
    check("tp_raw_data", obs_data, 16'hBEEF);
    check("tp_raw_err", obs_err, 0);

    set_req(1, 1, 8'h05, 16'h1234, 2'b11); step();
    set_req(1, 1, 8'h05, 16'hAB00, 2'b10); step(); clear_all();
    set_req(3, 0, 8'h05, 16'h0, 2'b00);    step(); clear_all();
    step(); step();
    check("tp_be_data", obs_data, 16'hAB34);

    foreach (grant_cnt[p]) grant_cnt[p] = 0;
    for (int p = 0; p < NP; p++) set_req(p, 0, 8'(p * 3), 16'h0, 2'b00);
    repeat (8) step();
    for (int p = 0; p < NP; p++) check($sformatf("fair_p%0d", p), grant_cnt[p], 2);
    p_valid[1] = 0;
    repeat (6) step();
    clear_all(); repeat (RL + 1) step();

    set_req(0, 1, 8'hF0, 16'h5A5A, 2'b11); step(); clear_all();
    step();
    check("tp_oor_wr_err", obs_wr_err, 1);
    set_req(1, 0, 8'hF0, 16'h0, 2'b00); step(); clear_all();
    set_req(2, 0, 8'hC7, 16'h0, 2'b00); step(); clear_all();
    step();
    check("tp_oor_rd_data", obs_data, 16'h0);
    check("tp_oor_rd_err", obs_err, 1);
    step();
    check("tp_c7_err", obs_err, 0);
    step();

    set_req(1, 0, 8'h20, 16'h0, 2'b00);
    set_req(3, 0, 8'h21, 16'h0, 2'b00);
    step(); step(); clear_all();
    enter_reset();
    repeat (3) step();
    reset_b = 1; in_reset = 0;
    set_req(0, 0, 8'h01, 16'h0, 2'b00);
    set_req(3, 0, 8'h02, 16'h0, 2'b00);
    step();
    check("tp_rst_ptr", obs_ready, 4'b0001);
    clear_all(); repeat (RL + 2) step();

    for (int p = 0; p < NP; p++) rand_port(p);
    repeat (400) begin
      step();
      for (int p = 0; p < NP; p++) if (!p_valid[p] || p == last_grant) rand_port(p);
    end
    clear_all(); repeat (RL + 2) step();

    for (int k = 0; k < 8; k++) begin
      bexp[k] = 16'($urandom);
      b_valid = 1; b_write = 1; b_addr = 8'(k); b_wdata = bexp[k]; b_be = 2'b11;
      @(negedge clock);
      check("b_wr_ready", b_ready, 1);
      @(posedge clock); #1;
    end
    for (int k = 0; k <= 8; k++) begin
      b_write = 0;
      b_valid = (k < 8);
      b_addr  = 8'(k % 8);
      @(negedge clock);
      if (k < 8) check("b_rd_ready", b_ready, 1);
      if (k > 0) begin
        check("b_rsp_valid", b_rsp_valid, 1);
        check("b_rsp_data", b_rdata, bexp[k-1]);
        check("b_rsp_err", b_rsp_error, 0);
      end
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("b_rsp_idle", b_rsp_valid, 0);
    check("b_rsp_hold", b_rdata, bexp[7]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
